// File: rtl/diaosi_types_pkg.sv
// rtl/diaosi_types_pkg.sv - shared pipeline hazard types and latch indices
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

    localparam logic [3:0] LATCH_ALL  = 4'b1111;
    localparam logic [3:0] LATCH_NONE = 4'b0000;

endpackage

// File: rtl/hz_sat_counter.sv
// rtl/hz_sat_counter.sv - saturating event counter with synchronous clear
module hz_sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_param.sv
// rtl/hazard_ctrl_param.sv - 5-stage pipeline hazard controller with stall FSM and perf counters
module hazard_ctrl_param
    import diaosi_types_pkg::*;
#(
    parameter int REG_W         = 5,
    parameter int LOAD_BUBBLES  = 1,
    parameter int RESOLVE_STAGE = 2,
    parameter int CNT_W         = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             xfer_taken,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_wsel,
    output logic             pc_en,
    output logic [3:0]       latch_en,
    output logic [3:0]       latch_flush,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] BUBBLES_M1 = 2'(LOAD_BUBBLES - 1);
    localparam logic [3:0] XFER_FLUSH = (RESOLVE_STAGE == 1) ? 4'b0001 : 4'b0011;

    hz_state_t  state, state_nxt;
    hz_state_t  saved, saved_nxt;
    hz_state_t  eff_state;
    logic [1:0] bcnt, bcnt_nxt;
    logic       lu_hit;
    logic       freeze;
    logic       flush_inc;
    logic       stall_inc;

    assign lu_hit = ex_memread && (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
    assign freeze = dmem_req && !dhit;

    // While frozen, decisions are made as if the pre-freeze state were current.
    assign eff_state = (state == MEM_WAIT) ? saved : state;

    always_comb begin
        pc_en       = 1'b1;
        latch_en    = LATCH_ALL;
        latch_flush = LATCH_NONE;
        state_nxt   = eff_state;
        saved_nxt   = saved;
        bcnt_nxt    = bcnt;
        flush_inc   = 1'b0;

        if (RST) begin
            pc_en       = 1'b0;
            latch_flush = LATCH_ALL;
            state_nxt   = RUN;
            saved_nxt   = RUN;
            bcnt_nxt    = 2'd0;
        end else if (freeze) begin
            pc_en     = 1'b0;
            latch_en  = LATCH_NONE;
            state_nxt = MEM_WAIT;
            if (state != MEM_WAIT) begin
                saved_nxt = state;
            end
        end else if (xfer_taken && ihit) begin
            latch_flush = XFER_FLUSH;
            state_nxt   = RUN;
            bcnt_nxt    = 2'd0;
            flush_inc   = 1'b1;
        end else if ((eff_state == LU_STALL) || ((eff_state == RUN) && lu_hit)) begin
            pc_en              = 1'b0;
            latch_en[IFID]     = 1'b0;
            latch_flush[IDEX]  = 1'b1;
            if (eff_state == RUN) begin
                if (LOAD_BUBBLES > 1) begin
                    state_nxt = LU_STALL;
                    bcnt_nxt  = BUBBLES_M1;
                end
            end else begin
                bcnt_nxt  = (bcnt == 2'd0) ? 2'd0 : bcnt - 2'd1;
                state_nxt = (bcnt <= 2'd1) ? RUN : LU_STALL;
            end
        end else if (!ihit) begin
            pc_en             = 1'b0;
            latch_flush[IFID] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            saved <= RUN;
            bcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            saved <= saved_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    assign hz_state  = state;
    assign stall_inc = !RST && !pc_en;

    hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb/tb_hazard_ctrl_param.sv - directed self-checking bench for hazard_ctrl_param
module tb_hazard_ctrl_param;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, dmem_req, xfer_taken;
    logic [4:0] id_rs, id_rt, ex_wsel;
    logic       id_uses_rt, ex_memread;

    logic        a_pc_en;
    logic [3:0]  a_latch_en, a_latch_flush;
    logic [1:0]  a_state;
    logic [31:0] a_stall_cnt, a_flush_cnt;

    logic        b_pc_en;
    logic [3:0]  b_latch_en, b_latch_flush;
    logic [1:0]  b_state;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_param #(.REG_W(5), .LOAD_BUBBLES(1), .RESOLVE_STAGE(2), .CNT_W(32)) u_a (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .xfer_taken(xfer_taken), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_wsel(ex_wsel), .pc_en(a_pc_en), .latch_en(a_latch_en),
        .latch_flush(a_latch_flush), .hz_state(a_state), .stall_cnt(a_stall_cnt),
        .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl_param #(.REG_W(5), .LOAD_BUBBLES(3), .RESOLVE_STAGE(1), .CNT_W(4)) u_b (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .xfer_taken(xfer_taken), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_wsel(ex_wsel), .pc_en(b_pc_en), .latch_en(b_latch_en),
        .latch_flush(b_latch_flush), .hz_state(b_state), .stall_cnt(b_stall_cnt),
        .flush_cnt(b_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic set_lu(input logic on);
        ex_memread = on;
        ex_wsel    = on ? 5'd8 : 5'd0;
        id_rs      = on ? 5'd8 : 5'd1;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b1; dhit = 1'b1; dmem_req = 1'b0; xfer_taken = 1'b0;
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_wsel = 5'd0;

        // reset outputs
        #2;
        chk("rst_pc_en", {31'd0, a_pc_en}, 32'd0);
        chk("rst_latch_en", {28'd0, a_latch_en}, 32'hF);
        chk("rst_latch_flush", {28'd0, a_latch_flush}, 32'hF);
        tick();
        RST = 1'b0;
        #1;
        chk("rst_state", {30'd0, a_state}, 32'd0);
        chk("rst_stall_cnt", a_stall_cnt, 32'd0);
        chk("rst_flush_cnt", a_flush_cnt, 32'd0);
        chk("run_pc_en", {31'd0, a_pc_en}, 32'd1);

        // single-bubble load-use
        set_lu(1'b1);
        #1;
        chk("lu1_pc_en", {31'd0, a_pc_en}, 32'd0);
        chk("lu1_latch_en", {28'd0, a_latch_en}, 32'hE);
        chk("lu1_latch_flush", {28'd0, a_latch_flush}, 32'h2);
        tick();
        set_lu(1'b0);
        #1;
        chk("lu1_after_pc_en", {31'd0, a_pc_en}, 32'd1);
        chk("lu1_after_state", {30'd0, a_state}, 32'd0);
        chk("lu1_stall_cnt", a_stall_cnt, 32'd1);

        // r0 exemption and rt usage gating
        ex_memread = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0;
        #1;
        chk("r0_pc_en", {31'd0, a_pc_en}, 32'd1);
        chk("r0_latch_flush", {28'd0, a_latch_flush}, 32'h0);
        ex_wsel = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        #1;
        chk("rt_unused_pc_en", {31'd0, a_pc_en}, 32'd1);
        id_uses_rt = 1'b1;
        #1;
        chk("rt_used_pc_en", {31'd0, a_pc_en}, 32'd0);
        chk("rt_used_flush", {28'd0, a_latch_flush}, 32'h2);
        id_uses_rt = 1'b0; id_rt = 5'd2;
        set_lu(1'b0);

        // three bubbles with a two-cycle data miss in the middle (instance b)
        do_reset();
        set_lu(1'b1);
        #1;
        chk("lu3_c1_flush", {28'd0, b_latch_flush}, 32'h2);
        chk("lu3_c1_en", {28'd0, b_latch_en}, 32'hE);
        tick();
        set_lu(1'b0);
        #1;
        chk("lu3_c2_state", {30'd0, b_state}, 32'd1);
        chk("lu3_c2_pc_en", {31'd0, b_pc_en}, 32'd0);
        chk("lu3_c2_flush", {28'd0, b_latch_flush}, 32'h2);
        tick();
        dmem_req = 1'b1; dhit = 1'b0;
        #1;
        chk("frz_c1_en", {28'd0, b_latch_en}, 32'h0);
        chk("frz_c1_flush", {28'd0, b_latch_flush}, 32'h0);
        chk("frz_c1_pc_en", {31'd0, b_pc_en}, 32'd0);
        tick();
        chk("frz_c2_state", {30'd0, b_state}, 32'd2);
        chk("frz_c2_en", {28'd0, b_latch_en}, 32'h0);
        tick();
        dmem_req = 1'b0; dhit = 1'b1;
        #1;
        chk("resume_en", {28'd0, b_latch_en}, 32'hE);
        chk("resume_flush", {28'd0, b_latch_flush}, 32'h2);
        tick();
        chk("lu3_done_state", {30'd0, b_state}, 32'd0);
        chk("lu3_done_pc_en", {31'd0, b_pc_en}, 32'd1);
        chk("lu3_stall_cnt", {28'd0, b_stall_cnt}, 32'd5);

        // taken transfer beats load-use
        do_reset();
        xfer_taken = 1'b1;
        set_lu(1'b1);
        #1;
        chk("xfer_a_flush", {28'd0, a_latch_flush}, 32'h3);
        chk("xfer_a_pc_en", {31'd0, a_pc_en}, 32'd1);
        chk("xfer_a_en", {28'd0, a_latch_en}, 32'hF);
        chk("xfer_b_flush", {28'd0, b_latch_flush}, 32'h1);
        tick();
        xfer_taken = 1'b0;
        set_lu(1'b0);
        #1;
        chk("xfer_a_state", {30'd0, a_state}, 32'd0);
        chk("xfer_b_state", {30'd0, b_state}, 32'd0);
        chk("xfer_a_flush_cnt", a_flush_cnt, 32'd1);
        chk("xfer_a_stall_cnt", a_stall_cnt, 32'd0);

        // transfer during fetch miss does not flush
        xfer_taken = 1'b1; ihit = 1'b0;
        #1;
        chk("xfer_miss_pc_en", {31'd0, a_pc_en}, 32'd0);
        chk("xfer_miss_flush", {28'd0, a_latch_flush}, 32'h1);
        tick();
        xfer_taken = 1'b0; ihit = 1'b1;
        #1;
        chk("xfer_miss_flush_cnt", a_flush_cnt, 32'd1);

        // transfer aborts an in-progress multi-bubble stall
        set_lu(1'b1);
        tick();
        set_lu(1'b0);
        #1;
        chk("abort_pre_state", {30'd0, b_state}, 32'd1);
        xfer_taken = 1'b1;
        #1;
        chk("abort_b_pc_en", {31'd0, b_pc_en}, 32'd1);
        chk("abort_b_flush", {28'd0, b_latch_flush}, 32'h1);
        tick();
        xfer_taken = 1'b0;
        #1;
        chk("abort_b_state", {30'd0, b_state}, 32'd0);
        chk("abort_b_flush_cnt", {28'd0, b_flush_cnt}, 32'd2);

        // instruction miss for four cycles
        do_reset();
        ihit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("imiss_pc_en_%0d", i), {31'd0, a_pc_en}, 32'd0);
            chk($sformatf("imiss_flush_%0d", i), {28'd0, a_latch_flush}, 32'h1);
            tick();
        end
        ihit = 1'b1;
        #1;
        chk("imiss_stall_cnt", a_stall_cnt, 32'd4);

        // reset in the middle of a load-use stall
        do_reset();
        set_lu(1'b1);
        tick();
        set_lu(1'b0);
        #1;
        chk("mid_rst_pre_state", {30'd0, b_state}, 32'd1);
        RST = 1'b1;
        #1;
        chk("mid_rst_pc_en", {31'd0, b_pc_en}, 32'd0);
        chk("mid_rst_flush", {28'd0, b_latch_flush}, 32'hF);
        tick();
        RST = 1'b0;
        #1;
        chk("mid_rst_state", {30'd0, b_state}, 32'd0);
        chk("mid_rst_stall_cnt", {28'd0, b_stall_cnt}, 32'd0);
        chk("mid_rst_pc_en_after", {31'd0, b_pc_en}, 32'd1);

        // 4-bit counter saturation
        ihit = 1'b0;
        repeat (20) tick();
        ihit = 1'b1;
        #1;
        chk("sat_stall_cnt", {28'd0, b_stall_cnt}, 32'd15);
        chk("nosat_stall_cnt", a_stall_cnt, 32'd20);
        tick();
        chk("sat_hold_cnt", {28'd0, b_stall_cnt}, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
- Parametrised hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates the PC enable plus per-latch enable and flush vectors for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Over the previous single-cycle combinational unit it adds:
  - a configurable branch-resolve stage;
  - a multi-bubble load-use stall FSM;
  - a full-pipeline freeze on data-memory miss;
  - an r0 hazard exemption;
  - saturating stall/flush performance counters.

Parameters:
- REG_W, 5, register index width.
- LOAD_BUBBLES, 1, bubbles inserted on load-use hazard; legal 1..3.
- RESOLVE_STAGE, 2, latch count flushed on taken transfer: 1 = resolved in ID (flush IF/ID), 2 = resolved in EX (flush IF/ID, ID/EX).
- CNT_W, 32, performance counter width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dmem_req  in  1  MEM stage holds a load/store.
- xfer_taken  in  1  jump, jr or taken branch resolved at RESOLVE_STAGE.
- id_rs  in  REG_W  ID-stage source register 1.
- id_rt  in  REG_W  ID-stage source register 2.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_wsel  in  REG_W  EX-stage destination register.
- pc_en  out  1  PC update enable.
- latch_en  out  4  latch enables; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
- latch_flush  out  4  latch flush (load bubble on enabled edge), same bit order.
- hz_state  out  2  current FSM state.
- stall_cnt  out  CNT_W  cycles with pc_en=0 outside reset.
- flush_cnt  out  CNT_W  taken-transfer flush events.

Behaviour:
- FSM states: RUN=0, LU_STALL=1, MEM_WAIT=2. Registered state plus bubble counter bcnt (2 bits). Outputs are combinational from state and inputs.
- Reset: while RST=1, all of the following hold, and they take effect on the next CLK edge:
  - pc_en=0, latch_en=4'b1111, latch_flush=4'b1111;
  - state=RUN, bcnt=0, stall_cnt=0, flush_cnt=0.
  - Reset mid-stall abandons the stall.
- lu_hit = ex_memread & (ex_wsel!=0) & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)). Register 0 never hazards.
- Per-cycle priority, highest first:
  1. dmem_req & !dhit: freeze. pc_en=0, latch_en=0000, latch_flush=0000. State enters/stays MEM_WAIT. bcnt holds, and the pre-freeze state is remembered so it resumes after the freeze.
  2. xfer_taken & ihit: pc_en=1, latch_en=1111, latch_flush[RESOLVE_STAGE-1:0]=1. Aborts LU_STALL: state=RUN, bcnt=0. flush_cnt+1.
  3. LU_STALL, or RUN with lu_hit:
     - pc_en=0, latch_en=1110 (IF/ID holds), latch_flush=0010 (bubble into ID/EX).
     - From RUN with LOAD_BUBBLES>1: go to LU_STALL, bcnt=LOAD_BUBBLES-1.
     - In LU_STALL: bcnt-1; return to RUN when bcnt reaches 0 after this cycle.
  4. !ihit: pc_en=0, latch_en=1111, latch_flush=0001 (bubble into ID, older stages drain).
  5. Otherwise: pc_en=1, latch_en=1111, latch_flush=0000.
- MEM_WAIT exit: the cycle dhit=1 evaluates priorities 2–5 against the saved state, and the next state follows from that.
- stall_cnt: +1 each non-reset cycle with pc_en=0.
- flush_cnt: +1 per priority-2 cycle.
- Both counters saturate at all-ones and never wrap.
- Simultaneous events:
  - xfer_taken with lu_hit: the flush wins; no bubble is inserted.
  - xfer_taken with !ihit: no flush that cycle; the transfer is held upstream by the datapath until ihit.

Decomposition:
- diaosi_types_pkg gains:
  - hz_state_t enum (RUN, LU_STALL, MEM_WAIT);
  - latch index constants IFID=0, IDEX=1, EXMEM=2, MEMWB=3.
- One sub-module, hz_sat_counter (width parameter, inc and RST inputs, saturating), instantiated twice.

Test Plan:
- Load-use, LOAD_BUBBLES=1: ex_memread=1, ex_wsel=8, id_rs=8 -> one cycle of pc_en=0, latch_en=1110, latch_flush=0010; next cycle RUN with pc_en=1; stall_cnt=1.
- r0 exemption: ex_memread=1, ex_wsel=0, id_rs=0 -> pc_en=1, no bubble.
- LOAD_BUBBLES=3: trigger lu_hit once -> exactly 3 consecutive bubble cycles. With dmem_req=1, dhit=0 for 2 cycles inserted mid-stall -> 2 frozen cycles (latch_en=0000), then the remaining bubbles resume. stall_cnt=5.
- RESOLVE_STAGE=2: xfer_taken=1, ihit=1 -> latch_flush=0011, pc_en=1, flush_cnt=1. Same cycle as lu_hit -> no bubble; state=RUN.
- Instruction miss: ihit=0 for 4 cycles -> pc_en=0, latch_flush=0001 each cycle; stall_cnt=4.
- Reset and saturation: assert RST in LU_STALL -> next cycle state=RUN, counters=0. With CNT_W=4, 20 stall cycles -> stall_cnt=15 held.
